matrix_framebuffer: RTL and testbench

MATRIX_FRAMEBUFFER -- requirements
Module: matrix_framebuffer

---
 rtl/matrix_framebuffer.sv | 98 +++++++++
 tb/tb_matrix_framebuffer.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/matrix_framebuffer.sv
// Double-buffered 8x8 red/green LED matrix framebuffer. Pixels are written into a
// back buffer, which is copied to the front buffer on a scan frame boundary.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// IDLE      | accepts pixel writes, clear and swap requests
// CLEAR     | zeroes one back-buffer row per cycle (rows 0..7)
// WAIT_SWAP | waits for frame_tick, then copies back buffer to the front buffer
module matrix_framebuffer (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            wr_en,
  input  logic [2:0]      wr_row,
  input  logic [2:0]      wr_col,
  input  logic [1:0]      wr_color,
  input  logic            clear_req,
  input  logic            swap_req,
  input  logic            frame_tick,
  output logic [7:0][7:0] red_array,
  output logic [7:0][7:0] green_array,
  output logic            busy,
  output logic            swap_done
);

  typedef enum logic [1:0] {IDLE, CLEAR, WAIT_SWAP} state_t;

  state_t          state;
  logic [7:0][7:0] back_red;
  logic [7:0][7:0] back_green;
  logic            pending;
  logic [2:0]      clr_row;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      back_red    <= '0;
      back_green  <= '0;
      red_array   <= '0;
      green_array <= '0;
      busy        <= 1'b0;
      swap_done   <= 1'b0;
      pending     <= 1'b0;
      clr_row     <= '0;
    end else begin
      swap_done <= 1'b0;
      case (state)
        IDLE: begin
          if (clear_req) begin
            // clear wins; a simultaneous swap is remembered for the end of CLEAR
            state   <= CLEAR;
            busy    <= 1'b1;
            clr_row <= '0;
            pending <= swap_req;
          end else begin
            if (wr_en) begin
              back_red[wr_row][wr_col]   <= wr_color[1];
              back_green[wr_row][wr_col] <= wr_color[0];
            end
            if (swap_req) begin
              state   <= WAIT_SWAP;
              busy    <= 1'b1;
              pending <= 1'b1;
            end
          end
        end
        CLEAR: begin
          back_red[clr_row]   <= '0;
          back_green[clr_row] <= '0;
          clr_row             <= clr_row + 3'd1;
          if (swap_req) pending <= 1'b1;
          if (clr_row == 3'd7) begin
            if (pending || swap_req) begin
              state <= WAIT_SWAP;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        WAIT_SWAP: begin
          if (frame_tick) begin
            red_array   <= back_red;
            green_array <= back_green;
            pending     <= 1'b0;
            state       <= IDLE;
            busy        <= 1'b0;
            swap_done   <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_framebuffer.sv
// Scoreboard bench for matrix_framebuffer: each swap request pushes the expected
// front-buffer image; a monitor checks it whenever swap_done pulses.
module tb_matrix_framebuffer;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            wr_en = 1'b0;
  logic [2:0]      wr_row = '0;
  logic [2:0]      wr_col = '0;
  logic [1:0]      wr_color = '0;
  logic            clear_req = 1'b0;
  logic            swap_req = 1'b0;
  logic            frame_tick = 1'b0;
  logic [7:0][7:0] red_array;
  logic [7:0][7:0] green_array;
  logic            busy;
  logic            swap_done;

  typedef struct {
    logic [63:0] r;
    logic [63:0] g;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  matrix_framebuffer dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .wr_en       (wr_en),
    .wr_row      (wr_row),
    .wr_col      (wr_col),
    .wr_color    (wr_color),
    .clear_req   (clear_req),
    .swap_req    (swap_req),
    .frame_tick  (frame_tick),
    .red_array   (red_array),
    .green_array (green_array),
    .busy        (busy),
    .swap_done   (swap_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // one cycle of inputs, applied at the falling edge
  task automatic step(input logic we, input int r, input int c, input logic [1:0] col,
                      input logic clr, input logic swp, input logic tick);
    @(negedge clk);
    wr_en      = we;
    wr_row     = 3'(r);
    wr_col     = 3'(c);
    wr_color   = col;
    clear_req  = clr;
    swap_req   = swp;
    frame_tick = tick;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 0, 0, 2'b00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic expect_swap(input logic [63:0] r, input logic [63:0] g);
    exp_t e;
    e.r = r;
    e.g = g;
    exp_q.push_back(e);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 20; i++) begin
      if (exp_q.size() == 0) break;
      idle(1);
    end
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: swap_done not seen, %0d swaps outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  // monitor: every swap_done must match the oldest outstanding swap
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (swap_done === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_swap_done: got swap_done=1 required no pulse");
        end else begin
          e = exp_q.pop_front();
          chk("swap_red", red_array, e.r);
          chk("swap_green", green_array, e.g);
          chk("swap_busy", 64'(busy), 64'd0);
        end
      end
    end
  end

  initial begin
    // reset state
    #12;
    chk("reset_red", red_array, 64'd0);
    chk("reset_green", green_array, 64'd0);
    chk("reset_busy_done", {62'd0, busy, swap_done}, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // single red pixel, tick 4 cycles after the swap request
    step(1'b1, 3, 5, 2'b10, 1'b0, 1'b0, 1'b0);
    step(1'b0, 0, 0, 2'b00, 1'b0, 1'b1, 1'b0);
    expect_swap(64'h00000000_20000000, 64'd0);
    idle(1);
    chk("swap_busy_wait", 64'(busy), 64'd1);
    idle(2);
    step(1'b0, 0, 0, 2'b00, 1'b0, 1'b0, 1'b1);
    idle(1);
    drain("drain_single");

    // write while busy is ignored
    step(1'b1, 2, 1, 2'b11, 1'b0, 1'b0, 1'b0);
    step(1'b0, 0, 0, 2'b00, 1'b0, 1'b1, 1'b0);
    expect_swap(64'h00000000_20020000, 64'h00000000_00020000);
    step(1'b1, 2, 1, 2'b00, 1'b0, 1'b0, 1'b0);
    idle(1);
    step(1'b0, 0, 0, 2'b00, 1'b0, 1'b0, 1'b1);
    idle(1);
    drain("drain_busy_write");

    // tick coinciding with swap_req must not copy
    step(1'b1, 0, 0, 2'b01, 1'b0, 1'b0, 1'b0);
    step(1'b0, 0, 0, 2'b00, 1'b0, 1'b1, 1'b1);
    expect_swap(64'h00000000_20020000, 64'h00000000_00020001);
    idle(1);
    chk("early_tick_busy", 64'(busy), 64'd1);
    chk("early_tick_green", green_array, 64'h00000000_00020000);
    idle(2);
    step(1'b0, 0, 0, 2'b00, 1'b0, 1'b0, 1'b1);
    idle(1);
    drain("drain_early_tick");

    // fill, then clear and swap together
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        step(1'b1, r, c, 2'b11, 1'b0, 1'b0, 1'b0);
    step(1'b1, 5, 5, 2'b00, 1'b1, 1'b1, 1'b0);
    expect_swap(64'd0, 64'd0);
    for (int i = 0; i < 10; i++) begin
      idle(1);
      chk("clear_busy", 64'(busy), 64'd1);
    end
    step(1'b0, 0, 0, 2'b00, 1'b0, 1'b0, 1'b1);
    idle(1);
    drain("drain_clear_swap");

    // corner pixels on consecutive cycles
    step(1'b1, 7, 7, 2'b01, 1'b0, 1'b0, 1'b0);
    step(1'b1, 0, 0, 2'b10, 1'b0, 1'b0, 1'b0);
    step(1'b0, 0, 0, 2'b00, 1'b0, 1'b1, 1'b0);
    expect_swap(64'h00000000_00000001, 64'h80000000_00000000);
    idle(2);
    step(1'b0, 0, 0, 2'b00, 1'b0, 1'b0, 1'b1);
    idle(1);
    drain("drain_corners");

    // reset in the middle of CLEAR
    step(1'b0, 0, 0, 2'b00, 1'b1, 1'b0, 1'b0);
    idle(3);
    #2;
    reset_n = 1'b0;
    #1;
    chk("midclear_red", red_array, 64'd0);
    chk("midclear_green", green_array, 64'd0);
    chk("midclear_busy_done", {62'd0, busy, swap_done}, 64'd0);
    idle(2);
    reset_n = 1'b1;
    wr_en = 1'b1; wr_row = 3'd4; wr_col = 3'd4; wr_color = 2'b11;
    step(1'b0, 0, 0, 2'b00, 1'b0, 1'b1, 1'b0);
    chk("post_reset_busy", 64'(busy), 64'd0);
    expect_swap(64'h00000010_00000000, 64'h00000010_00000000);
    idle(1);
    chk("post_reset_swap_busy", 64'(busy), 64'd1);
    step(1'b0, 0, 0, 2'b00, 1'b0, 1'b0, 1'b1);
    idle(1);
    drain("drain_post_reset");
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
